// File: rtl/intersection_pkg.sv
// Shared types, default phase durations and lamp decode for the intersection controller.
package intersection_pkg;

  typedef enum logic [2:0] {
    AR   = 3'd0,
    NS_G = 3'd1,
    NS_Y = 3'd2,
    EW_G = 3'd3,
    EW_Y = 3'd4,
    WALK = 3'd5
  } state_t;

  typedef enum logic {
    NS = 1'b0,
    EW = 1'b1
  } dir_t;

  localparam int DEF_TW          = 4;
  localparam int DEF_GREEN_TIME  = 4;
  localparam int DEF_YELLOW_TIME = 2;
  localparam int DEF_ALLRED_TIME = 1;
  localparam int DEF_WALK_TIME   = 3;

  // Lamp vector order: {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk}.
  // Anything that is not a vehicle phase shows both reds, so illegal codes stay safe.
  function automatic logic [6:0] decode_lamps(input state_t s);
    case (s)
      NS_G:    return 7'b0011000;
      NS_Y:    return 7'b0101000;
      EW_G:    return 7'b1000010;
      EW_Y:    return 7'b1000100;
      WALK:    return 7'b1001001;
      default: return 7'b1001000;
    endcase
  endfunction

endpackage

// File: rtl/intersection_ctrl_phase_timer.sv
// Loadable down-counter that times each phase; zero marks the last cycle of a phase.
module phase_timer #(
  parameter int            TW        = 4,
  parameter logic [TW-1:0] RESET_VAL = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          zero
);

  logic [TW-1:0] count;

  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              count <= RESET_VAL;
    else if (load)          count <= load_val;
    else if (count != '0)   count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/intersection_ctrl.sv
// Two-approach intersection scheduler: NS/EW green-yellow-allred sequencing with a
// latched pedestrian walk phase served from the all-red gap.
module intersection_ctrl
  import intersection_pkg::*;
#(
  parameter int TW          = DEF_TW,
  parameter int GREEN_TIME  = DEF_GREEN_TIME,
  parameter int YELLOW_TIME = DEF_YELLOW_TIME,
  parameter int ALLRED_TIME = DEF_ALLRED_TIME,
  parameter int WALK_TIME   = DEF_WALK_TIME
) (
  input  logic clk,
  input  logic reset,
  input  logic ped_req,
  output logic ped_ack,
  output logic ns_red,
  output logic ns_yellow,
  output logic ns_green,
  output logic ew_red,
  output logic ew_yellow,
  output logic ew_green,
  output logic walk
);

  localparam logic [TW-1:0] G_T = GREEN_TIME[TW-1:0];
  localparam logic [TW-1:0] Y_T = YELLOW_TIME[TW-1:0];
  localparam logic [TW-1:0] A_T = ALLRED_TIME[TW-1:0];
  localparam logic [TW-1:0] W_T = WALK_TIME[TW-1:0];

  state_t        state, state_nxt;
  dir_t          next_dir, dir_nxt;
  logic          ped_pend;
  logic          grant;
  logic          load;
  logic          zero;
  logic [TW-1:0] load_val;

  function automatic logic [TW-1:0] phase_time(input state_t s);
    case (s)
      NS_G, EW_G: return G_T;
      NS_Y, EW_Y: return Y_T;
      WALK:       return W_T;
      default:    return A_T;
    endcase
  endfunction

  phase_timer #(
    .TW        (TW),
    .RESET_VAL (A_T)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .zero     (zero)
  );

  // The timer reloads with the duration of whichever phase is being entered.
  assign load_val = phase_time(state_nxt);

  // NOTE: every output of this block gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    dir_nxt   = next_dir;
    load      = 1'b0;
    grant     = 1'b0;
    case (state)
      AR: if (zero) begin
        load = 1'b1;
        if (ped_pend || ped_req) begin
          state_nxt = WALK;
          grant     = 1'b1;
        end else begin
          state_nxt = (next_dir == NS) ? NS_G : EW_G;
        end
      end
      NS_G: if (zero) begin
        load      = 1'b1;
        state_nxt = NS_Y;
      end
      NS_Y: if (zero) begin
        load      = 1'b1;
        state_nxt = AR;
        dir_nxt   = EW;
      end
      EW_G: if (zero) begin
        load      = 1'b1;
        state_nxt = EW_Y;
      end
      EW_Y: if (zero) begin
        load      = 1'b1;
        state_nxt = AR;
        dir_nxt   = NS;
      end
      WALK: if (zero) begin
        load      = 1'b1;
        state_nxt = (next_dir == NS) ? NS_G : EW_G;
      end
      default: begin
        load      = 1'b1;
        state_nxt = AR;
        dir_nxt   = NS;
      end
    endcase
  end

  // Lamps are registered from the next state, so they always equal the decode of
  // the state register and ped_req never reaches an output combinationally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= AR;
      next_dir <= NS;
      ped_pend <= 1'b0;
      ped_ack  <= 1'b0;
      {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk} <= decode_lamps(AR);
    end else begin
      state    <= state_nxt;
      next_dir <= dir_nxt;
      ped_ack  <= grant;
      if (grant)                           ped_pend <= 1'b0;
      else if (ped_req && state != WALK)   ped_pend <= 1'b1;
      {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk} <= decode_lamps(state_nxt);
    end
  end

endmodule

// File: tb/tb_intersection_ctrl.sv
// Self-checking bench for intersection_ctrl: directed phase/pedestrian scenarios plus
// randomized requests against a lamp-pattern-level reference model.
module tb_intersection_ctrl;

  localparam int GT = 4, YT = 2, AT = 1, WT = 3;
  localparam int MAX_LAT = 22;

  localparam logic [6:0] L_AR   = 7'b1001000;
  localparam logic [6:0] L_NSG  = 7'b0011000;
  localparam logic [6:0] L_NSY  = 7'b0101000;
  localparam logic [6:0] L_EWG  = 7'b1000010;
  localparam logic [6:0] L_EWY  = 7'b1000100;
  localparam logic [6:0] L_WALK = 7'b1001001;

  logic clk = 1'b0;
  logic reset;
  logic ped_req;
  logic ped_ack;
  logic ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk;
  logic [6:0] lamps;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  intersection_ctrl #(
    .TW (4), .GREEN_TIME (GT), .YELLOW_TIME (YT), .ALLRED_TIME (AT), .WALK_TIME (WT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ped_req   (ped_req),
    .ped_ack   (ped_ack),
    .ns_red    (ns_red),
    .ns_yellow (ns_yellow),
    .ns_green  (ns_green),
    .ew_red    (ew_red),
    .ew_yellow (ew_yellow),
    .ew_green  (ew_green),
    .walk      (walk)
  );

  assign lamps = {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: the phase is identified by its lamp pattern and aged in whole cycles.
  function automatic int dur(input logic [6:0] p);
    if (p == L_NSG || p == L_EWG) return GT + 1;
    if (p == L_NSY || p == L_EWY) return YT + 1;
    if (p == L_WALK)              return WT + 1;
    return AT + 1;
  endfunction

  logic [6:0] m_ph, m_prev;
  int         m_age;
  int         cyc;
  bit         m_ew_next, m_pend, m_ack, m_grant, m_req_evt;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ph = L_AR; m_age = 1; m_ew_next = 0; m_pend = 0; m_ack = 0; m_req_evt = 0; cyc = 0;
    end else begin
      m_prev    = m_ph;
      m_grant   = 0;
      cyc++;
      m_req_evt = ped_req && (m_prev != L_WALK);
      if (m_age < dur(m_ph)) m_age++;
      else begin
        m_age = 1;
        if (m_ph == L_NSG)      m_ph = L_NSY;
        else if (m_ph == L_NSY) begin m_ph = L_AR; m_ew_next = 1; end
        else if (m_ph == L_EWG) m_ph = L_EWY;
        else if (m_ph == L_EWY) begin m_ph = L_AR; m_ew_next = 0; end
        else if (m_ph == L_AR && (m_pend || ped_req)) begin m_ph = L_WALK; m_grant = 1; end
        else m_ph = m_ew_next ? L_EWG : L_NSG;
      end
      if (m_grant)        m_pend = 0;
      else if (m_req_evt) m_pend = 1;
      m_ack = m_grant;
    end
  end

  // Per-cycle comparison against the model, safety invariants and request latency.
  bit lat_open;
  int lat_t0;

  always @(negedge clk) begin
    if (reset) lat_open = 0;
    else begin
      if (m_req_evt && !lat_open) begin lat_open = 1; lat_t0 = cyc; end
      if (ped_ack && lat_open) begin
        check("ack_latency_ok", 32'((cyc - lat_t0) <= MAX_LAT), 1);
        lat_open = 0;
      end else if (lat_open && (cyc - lat_t0) > MAX_LAT) begin
        check("ack_timeout", cyc - lat_t0, MAX_LAT);
        lat_open = 0;
      end
    end
    check("lamps_vs_model", lamps, m_ph);
    check("ack_vs_model", ped_ack, m_ack);
    check("red_safety", ns_red | ew_red, 1);
    check("one_lamp_per_head",
          32'(($countones({ns_red, ns_yellow, ns_green}) == 1) &&
              ($countones({ew_red, ew_yellow, ew_green}) == 1)), 1);
    check("walk_only_all_red", 32'(!walk || (ns_red && ew_red)), 1);
  end

  task automatic wait_lamp(input logic [6:0] mask, input logic [6:0] val, input string tag);
    int n = 0;
    while (((lamps & mask) != val) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if ((lamps & mask) != val) check(tag, lamps & mask, val);
  endtask

  logic [6:0] run_pat[$];
  int         run_len[$];
  int         run_ack[$];

  // Run-length record of lamp patterns; called at a negedge, leaves at a negedge.
  task automatic record(input int n);
    run_pat.delete(); run_len.delete(); run_ack.delete();
    for (int i = 0; i < n; i++) begin
      if (run_pat.size() == 0 || run_pat[run_pat.size()-1] != lamps) begin
        run_pat.push_back(lamps);
        run_len.push_back(1);
        run_ack.push_back(int'(ped_ack));
      end else begin
        run_len[run_len.size()-1] = run_len[run_len.size()-1] + 1;
        run_ack[run_ack.size()-1] = run_ack[run_ack.size()-1] + int'(ped_ack);
      end
      @(negedge clk);
    end
  endtask

  function automatic int walk_runs(input int from);
    int c = 0;
    for (int i = from; i < run_pat.size(); i++) if (run_pat[i][0]) c++;
    return c;
  endfunction

  task automatic pulse_req();
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
  endtask

  logic [6:0] exp_pat[7];
  int         exp_len[7];
  int         held;

  initial begin
    reset   = 1'b1;
    ped_req = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_lamps", lamps, L_AR);
    check("reset_ack", ped_ack, 0);

    // Free run with no pedestrians: exact phase lengths.
    reset = 1'b0;
    record(40);
    exp_pat = '{L_AR, L_NSG, L_NSY, L_AR, L_EWG, L_EWY, L_AR};
    exp_len = '{AT+1, GT+1, YT+1, AT+1, GT+1, YT+1, AT+1};
    for (int i = 0; i < 7; i++) begin
      check($sformatf("free_pat%0d", i), run_pat[i], exp_pat[i]);
      check($sformatf("free_len%0d", i), run_len[i], exp_len[i]);
    end
    check("free_no_walk", walk_runs(0), 0);

    // One-cycle request in the 2nd NS_G cycle.
    wait_lamp(7'h7f, L_NSG, "wait_nsg");
    @(negedge clk);
    pulse_req();
    record(25);
    check("p1_nsg_rest", run_len[0], 3);
    check("p1_nsy", run_pat[1], L_NSY);
    check("p1_ar_pat", run_pat[2], L_AR);
    check("p1_ar_len", run_len[2], AT+1);
    check("p1_walk_pat", run_pat[3], L_WALK);
    check("p1_walk_len", run_len[3], WT+1);
    check("p1_walk_acks", run_ack[3], 1);
    check("p1_then_ewg", run_pat[4], L_EWG);

    // Request on the exact AR timeout edge.
    wait_lamp(7'h7f, L_EWY, "wait_ewy");
    wait_lamp(7'h7f, L_AR, "wait_ar");
    @(negedge clk);
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
    check("edge_walk", walk, 1);
    check("edge_ack", ped_ack, 1);
    @(negedge clk);
    check("edge_ack_single", ped_ack, 0);
    record(20);
    check("edge_walk_rest", run_len[0], WT);
    check("edge_then_nsg", run_pat[1], L_NSG);
    check("edge_no_rewalk", walk_runs(1), 0);

    // ped_req held high throughout WALK.
    pulse_req();
    wait_lamp(7'h01, 7'h01, "wait_walk_hold");
    ped_req = 1'b1;
    held = 0;
    while (walk && held < 10) begin
      held++;
      @(negedge clk);
    end
    ped_req = 1'b0;
    check("hold_walk_len", held, WT+1);
    record(20);
    check("hold_no_rewalk", walk_runs(0), 0);

    // Asynchronous reset in WALK cycle 2.
    pulse_req();
    wait_lamp(7'h01, 7'h01, "wait_walk_rst");
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_walk_drop", walk, 0);
    check("rst_both_red", lamps, L_AR);
    @(negedge clk);
    reset = 1'b0;
    record(22);
    check("rst_ar_pat", run_pat[0], L_AR);
    check("rst_ar_len", run_len[0], AT+1);
    check("rst_then_nsg", run_pat[1], L_NSG);
    check("rst_no_walk", walk_runs(0), 0);

    // Randomized requests; the always-block checkers do the work.
    for (int i = 0; i < 2000; i++) begin
      ped_req = ($urandom_range(0, 11) == 0);
      @(negedge clk);
    end
    ped_req = 1'b0;
    repeat (30) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/intersection_ctrl.md
# intersection_ctrl

Two-approach intersection controller that sequences north-south (NS) and east-west (EW) signal heads through green, yellow and all-red clearance phases. It also serves a latched pedestrian walk request during an all-red gap. It is the top-level scheduler of the traffic-light design: it shares the single intersection between the two vehicle approaches and the pedestrian crossing, and drives all lamp outputs. It is a Moore machine with a countdown phase timer.

## Interface
- TW, 4: phase timer width in bits; every *_TIME must be ≤ 2^TW−1
- GREEN_TIME, 4: green duration code (phase lasts GREEN_TIME+1 cycles)
- YELLOW_TIME, 2: yellow duration code
- ALLRED_TIME, 1: all-red clearance duration code
- WALK_TIME, 3: pedestrian walk duration code

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- ped_req  in  1  pedestrian request, sampled each edge; a one-cycle pulse is sufficient
- ped_ack  out  1  one-cycle pulse: the request has been granted
- ns_red, ns_yellow, ns_green  out  1 each  NS lamps, exactly one high
- ew_red, ew_yellow, ew_green  out  1 each  EW lamps, exactly one high
- walk  out  1  pedestrian walk lamp

## Operation
- States: AR (all-red), NS_G, NS_Y, EW_G, EW_Y, WALK.
- Registers:
  - state
  - timer[TW-1:0]
  - next_dir: NS or EW, the green to serve after AR/WALK
  - ped_pend
  - ped_ack
- Every state loads its *_TIME on entry and decrements by 1 each cycle. The transition is taken on the edge where timer==0. A state with code D therefore lasts D+1 cycles; D=0 lasts 1 cycle.
- Transitions at timer==0:
  - NS_G→NS_Y
  - NS_Y→AR, with next_dir←EW
  - EW_G→EW_Y
  - EW_Y→AR, with next_dir←NS
  - AR→WALK if (ped_pend | ped_req), else to the green of next_dir
  - WALK→green of next_dir
- ped_pend is set on any edge where ped_req=1, except in the cases below. A second request while pending has no further effect.
- On the AR→WALK edge: ped_pend←0 and ped_ack←1 for exactly the first WALK cycle. A ped_req on this same edge is absorbed into this grant.
- ped_req while in WALK is ignored and does not set ped_pend.
- Output decode, from the state register only:
  - AR and WALK: both reds high.
  - NS_G/NS_Y: ns_green/ns_yellow high, ew_red high. EW phases are the mirror.
  - walk=1 only in WALK.
- Safety invariant: ns_red|ew_red is high in every cycle. A non-red lamp on both heads simultaneously never occurs.
- Illegal state encoding: go to AR, timer←ALLRED_TIME, next_dir←NS.

## Timing
- Reset values (asynchronous, held while reset=1):
  - state=AR, timer=ALLRED_TIME, next_dir=NS, ped_pend=0, ped_ack=0
  - Outputs: ns_red=ew_red=1, every other lamp 0, walk=0
- First green (NS_G) appears ALLRED_TIME+1 edges after reset deasserts.
- Full vehicle cycle without pedestrians: 2·(GREEN_TIME+YELLOW_TIME+ALLRED_TIME+3) cycles; 20 with the defaults.
- Worst-case request-to-grant latency: one full cycle plus ALLRED_TIME+1 cycles.
- Lamp outputs change only on the edge after the timer==0 cycle. There is no combinational path from ped_req to any output.
- Reset asserted mid-phase, including mid-WALK: lamps go to both-red and walk=0 immediately. A pending request is discarded.

## Structure
- Shared package intersection_pkg:
  - state enum (AR, NS_G, NS_Y, EW_G, EW_Y, WALK)
  - dir enum (NS, EW)
  - default duration constants
- Sub-module phase_timer (TW-bit loadable down-counter):
  - inputs: load, load_val
  - output: zero flag
- The FSM, pending flag and output decode stay in intersection_ctrl.

## Test plan
- Reset then free-run 40 cycles with ped_req=0:
  - AR 2, NS_G 5, NS_Y 3, AR 2, EW_G 5, EW_Y 3, AR 2, NS_G … cycle counts exact
  - walk and ped_ack never high
- One-cycle ped_req pulse in the 2nd NS_G cycle:
  - after NS_Y the controller runs AR 2, then WALK 4 cycles with walk=1
  - ped_ack high only in the first WALK cycle, then EW_G
- ped_req asserted on the exact edge AR times out: WALK entered at once, single ped_ack, ped_pend=0 afterwards.
- ped_req held high throughout WALK: no second WALK at the next AR unless ped_req is still high at that AR timeout.
- Reset pulsed during WALK cycle 2:
  - walk drops and both reds are high asynchronously
  - after release, the normal AR→NS_G sequence resumes with no WALK
- Randomized ped_req over 2000 cycles:
  - assert ns_red|ew_red every cycle, exactly one lamp per head, walk only while both reds are high
  - every request acked within 22 cycles
